pc_cmd_deframer: RTL

- Sits directly downstream of the PC-to-FPGA write FIFO, in the CLK domain.
- Pops 32-bit pc_msg words through the FIFO's first-word-fall-through valid/ack interface and assembles them into 3-word host commands.
- Classifies each command as START, STOP or malformed, and hands valid commands to the application over a registered valid/ready interface.
- Keeps saturating counters of accepted and rejected commands for LED/status readout.

---
 rtl/pc_cmd_deframer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pc_cmd_deframer.sv
// Pops 32-bit pc_msg words from a FWFT FIFO, assembles 3-word host commands,
// classifies them as START/STOP/malformed. Optional idle timeout: PC_CMD_TIMEOUT_EN.
module pc_cmd_deframer #(
    parameter int unsigned DELAY   = 1,
    parameter int unsigned XB_SIZE = 32,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   pc_msg_valid,
    input  logic [XB_SIZE-1:0]     pc_msg,
    output logic                   pc_msg_ack,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [3*XB_SIZE-1:0]   cmd,
    output logic                   cmd_is_stop,
    output logic                   bad_cmd,
    output logic [CNT_W-1:0]       n_cmd,
    output logic [CNT_W-1:0]       n_bad
);

    logic [1:0]             r_idx;
    logic [XB_SIZE-1:0]     r_w0;
    logic [XB_SIZE-1:0]     r_w1;
    logic                   r_cmd_valid;
    logic [3*XB_SIZE-1:0]   r_cmd;
    logic                   r_cmd_is_stop;
    logic                   r_bad_cmd;
    logic [CNT_W-1:0]       r_n_cmd;
    logic [CNT_W-1:0]       r_n_bad;

    logic                   w_stall;
    logic                   w_ack;
    logic                   w_last;
    logic [3*XB_SIZE-1:0]   w_word;
    logic                   w_is_stop;
    logic                   w_is_start;
    logic                   w_accept;
    logic                   w_reject;
    logic                   w_timeout;

    // Register updates carry no delay; DELAY is kept for instantiation compatibility.
    if (DELAY > 32'd0) begin : g_delay_param
    end

    assign w_stall    = r_cmd_valid && !cmd_ready;
    assign w_ack      = pc_msg_valid && !w_stall && !RESET;
    assign w_last     = w_ack && (r_idx == 2'd2);
    assign w_word     = {pc_msg, r_w1, r_w0};
    assign w_is_stop  = (w_word == '0);
    assign w_is_start = (pc_msg != '0);
    assign w_accept   = w_last && (w_is_stop || w_is_start);
    assign w_reject   = (w_last && !w_accept) || w_timeout;

`ifdef PC_CMD_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] r_idle;

    // Drop a partial command once the gap between its words reaches TIMEOUT cycles.
    assign w_timeout = (r_idx != 2'd0) && !w_ack && !w_stall &&
                       (r_idle == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_idle <= '0;
        end else if (w_ack || w_timeout) begin
            r_idle <= '0;
        end else if ((r_idx != 2'd0) && !w_stall) begin
            r_idle <= r_idle + IDLE_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;

    if (TIMEOUT == 32'd0) begin : g_timeout_param
    end
`endif

    // Word index and partial-command shadow.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_idx <= 2'd0;
            r_w0  <= '0;
            r_w1  <= '0;
        end else if (w_timeout) begin
            r_idx <= 2'd0;
        end else if (w_ack) begin
            case (r_idx)
                2'd0:    r_w0 <= pc_msg;
                2'd1:    r_w1 <= pc_msg;
                default: ;
            endcase
            r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
        end
    end

    // Output holding register; a new command may replace one being taken.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cmd_valid   <= 1'b0;
            r_cmd         <= '0;
            r_cmd_is_stop <= 1'b0;
        end else if (w_accept) begin
            r_cmd_valid   <= 1'b1;
            r_cmd         <= w_word;
            r_cmd_is_stop <= w_is_stop;
        end else if (cmd_ready) begin
            r_cmd_valid   <= 1'b0;
        end
    end

    // Reject pulse and saturating status counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_bad_cmd <= 1'b0;
            r_n_cmd   <= '0;
            r_n_bad   <= '0;
        end else begin
            r_bad_cmd <= w_reject;
            if (w_accept && (r_n_cmd != '1)) begin
                r_n_cmd <= r_n_cmd + CNT_W'(1);
            end
            if (w_reject && (r_n_bad != '1)) begin
                r_n_bad <= r_n_bad + CNT_W'(1);
            end
        end
    end

    assign pc_msg_ack  = w_ack;
    assign cmd_valid   = r_cmd_valid;
    assign cmd         = r_cmd;
    assign cmd_is_stop = r_cmd_is_stop;
    assign bad_cmd     = r_bad_cmd;
    assign n_cmd       = r_n_cmd;
    assign n_bad       = r_n_bad;

endmodule
